// File: rtl/fanout_fork_if.sv
// fanout_fork_if: producer/consumer stream bundle around the fanout fork.
//
// Handshake rules, used on both sides:
//   A token moves on a channel in a cycle where valid and ready are both high
//   at the rising clock edge. A source holds valid and data stable until that
//   happens. A sink may drive ready regardless of valid.
//   On the fanout side each destination i forms its own channel
//   (out_valid[i], out_ready[i]), and all destinations share out_data.
//
// Signals:
//   in_valid / in_data / in_ready     producer -> fork channel
//   out_valid / out_data / out_ready  fork -> destination channels
// Modports:
//   master : the environment side (drives producer data and destination ready)
//   slave  : the fork controller side
interface fanout_fork_if #(
  parameter int NUM_OUT    = 9,
  parameter int DATA_WIDTH = 17
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [NUM_OUT-1:0]    out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fanout_fork_ctrl.sv
// fanout_fork_ctrl: buffered eager fork for a one-to-many ready/valid fanout.
//
// Captures one producer token, presents it to every routed destination and
// tracks which destinations still owe a handshake. The producer is released
// in the cycle the last pending destination accepts, so a new token can be
// captured back-to-back with the completion of the previous one.
//
// Ports:
//   clk, rst_n    tile clock, asynchronous active-low reset
//   flush         synchronous clear of the buffered token (counters kept)
//   cfg_route     per-destination route enable, latched on accept
//   io            fanout_fork_if slave modport (producer + destination channels)
//   busy          a token is held with at least one pending destination;
//                 also serves as the externally visible controller state
//   tok_count     accepted tokens, saturating
//   stall_count   cycles busy without completing, saturating
module fanout_fork_ctrl #(
  parameter int NUM_OUT    = 9,
  parameter int DATA_WIDTH = 17,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NUM_OUT-1:0]   cfg_route,
  fanout_fork_if.slave         io,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] tok_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_OUT-1:0]    pending_q;
  logic [CNT_WIDTH-1:0]  tok_cnt_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;

  logic [NUM_OUT-1:0]    take;
  logic                  last;
  logic                  accept;
  logic                  in_ready_int;

  // Ready from a destination that is not pending is masked off here, so it
  // can never complete a token it was not routed to.
  assign take         = pending_q & io.out_ready;
  assign busy         = |pending_q;
  assign last         = busy & ((pending_q & ~take) == '0);
  // Depends on out_ready only; no path from in_valid back to in_ready.
  assign in_ready_int = ~busy | last;
  assign accept       = io.in_valid & in_ready_int;

  assign io.in_ready  = in_ready_int;
  assign io.out_valid = pending_q;
  assign io.out_data  = data_q;
  assign tok_count    = tok_cnt_q;
  assign stall_count  = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      pending_q   <= '0;
      tok_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      // Flush beats a concurrent accept: the offered token is dropped and
      // data_q keeps the previous value.
      if (flush) begin
        pending_q <= '0;
      end else if (accept) begin
        data_q    <= io.in_data;
        // An all-zero route consumes the token with nothing left pending.
        pending_q <= cfg_route;
      end else begin
        pending_q <= pending_q & ~io.out_ready;
      end

      if (accept && !flush && !(&tok_cnt_q)) begin
        tok_cnt_q <= tok_cnt_q + CNT_ONE;
      end

      if (busy && !last && !flush && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
module tb_fanout_fork_ctrl;

  localparam int NO = 9;
  localparam int DW = 17;
  localparam int CMAX = 65535;

  logic clk;
  logic rst_n;
  logic flush;
  logic [NO-1:0] cfg_route;
  logic busy, busy_s;
  logic [15:0] tok_count, stall_count;
  logic [3:0] tok_count_s, stall_count_s;

  int checks = 0;
  int errors = 0;

  fanout_fork_if #(.NUM_OUT(NO), .DATA_WIDTH(DW)) io();
  fanout_fork_if #(.NUM_OUT(NO), .DATA_WIDTH(DW)) io_s();

  fanout_fork_ctrl #(.NUM_OUT(NO), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_route(cfg_route),
    .io(io), .busy(busy), .tok_count(tok_count), .stall_count(stall_count)
  );

  fanout_fork_ctrl #(.NUM_OUT(NO), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_route(cfg_route),
    .io(io_s), .busy(busy_s), .tok_count(tok_count_s), .stall_count(stall_count_s)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A token is "outstanding" for the set of destinations that still owe a
  // handshake; exp_q holds outstanding tokens in order.
  int m_rem [NO];
  logic [DW-1:0] m_data;
  int m_tok, m_stall;
  logic [DW-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < NO; i++) m_rem[i] = 0;
    m_data = '0;
    m_tok = 0;
    m_stall = 0;
    exp_q.delete();
  endtask

  function automatic int rem_count();
    int n = 0;
    for (int i = 0; i < NO; i++) n += m_rem[i];
    return n;
  endfunction

  function automatic int rem_ready_count(logic [NO-1:0] rdy);
    int n = 0;
    for (int i = 0; i < NO; i++) if (m_rem[i] == 1 && rdy[i]) n++;
    return n;
  endfunction

  function automatic logic exp_busy();
    return rem_count() > 0;
  endfunction

  function automatic logic exp_in_ready();
    return (rem_count() == 0) || (rem_count() == rem_ready_count(io.out_ready));
  endfunction

  function automatic logic [NO-1:0] exp_out_valid();
    logic [NO-1:0] v = '0;
    for (int i = 0; i < NO; i++) v[i] = (m_rem[i] == 1);
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_out_data();
    if (exp_q.size() > 0) return exp_q[0];
    return m_data;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int rc = rem_count();
    int rrc = rem_ready_count(io.out_ready);
    bit bsy = rc > 0;
    bit done = bsy && (rc == rrc);
    bit acc = io.in_valid && (!bsy || done);
    if (bsy && !done && !flush) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
    if (flush) begin
      for (int i = 0; i < NO; i++) m_rem[i] = 0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (acc) begin
      if (done) void'(exp_q.pop_front());
      m_data = io.in_data;
      for (int i = 0; i < NO; i++) m_rem[i] = cfg_route[i] ? 1 : 0;
      if (cfg_route != '0) exp_q.push_back(io.in_data);
      m_tok = (m_tok + 1 > CMAX) ? CMAX : m_tok + 1;
    end else begin
      for (int i = 0; i < NO; i++) if (io.out_ready[i]) m_rem[i] = 0;
      if (done) void'(exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  // drive: set inputs after the falling edge, settle, leave time for checks.
  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] id,
                       input logic [NO-1:0] cfg, input logic [NO-1:0] rdy);
    @(negedge clk);
    flush = fl;
    io.in_valid = iv;
    io.in_data = id;
    cfg_route = cfg;
    io.out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b0;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.out_ready = '0;
    cfg_route = '0;
    io_s.in_valid = 1'b0;
    io_s.in_data = '0;
    io_s.out_ready = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", io.in_ready); end
    checks++; if (io.out_valid !== '0) begin errors++; $display("FAIL rst_out_valid: got %h expected 0", io.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (io.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", io.out_data); end
    checks++; if (tok_count !== 16'd0 || stall_count !== 16'd0) begin errors++; $display("FAIL rst_counters: got %0d/%0d expected 0/0", tok_count, stall_count); end
    do_reset();
  endtask

  task automatic test_broadcast();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b1, DW'(k), 9'h1FF, 9'h1FF);
      checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL bc_in_ready k=%0d: got %b expected 1", k, io.in_ready); end
      if (k > 1) begin
        checks++; if (io.out_valid !== 9'h1FF || io.out_data !== DW'(k-1)) begin errors++; $display("FAIL bc_out k=%0d: got %h/%h expected 1ff/%h", k, io.out_valid, io.out_data, DW'(k-1)); end
      end
      tick();
    end
    drive(1'b0, 1'b0, '0, 9'h1FF, 9'h1FF);
    checks++; if (io.out_valid !== 9'h1FF || io.out_data !== DW'(5)) begin errors++; $display("FAIL bc_out_last: got %h/%h expected 1ff/5", io.out_valid, io.out_data); end
    tick();
    drive(1'b0, 1'b0, '0, 9'h1FF, 9'h1FF);
    checks++; if (tok_count !== 16'd5 || stall_count !== 16'd0) begin errors++; $display("FAIL bc_counts: got %0d/%0d expected 5/0", tok_count, stall_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bc_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_staggered();
    logic [NO-1:0] rdy_seq [6];
    logic [NO-1:0] vld_seq [6];
    logic          rdy_in  [6];
    rdy_seq = '{9'h000, 9'h001, 9'h000, 9'h004, 9'h000, 9'h002};
    vld_seq = '{9'h000, 9'h007, 9'h006, 9'h006, 9'h002, 9'h002};
    rdy_in  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b1, (c == 0) ? 17'h1ABCD : 17'h00042, 9'h007, rdy_seq[c]);
      checks++; if (io.out_valid !== vld_seq[c]) begin errors++; $display("FAIL stag_valid c=%0d: got %h expected %h", c, io.out_valid, vld_seq[c]); end
      checks++; if (io.in_ready !== rdy_in[c]) begin errors++; $display("FAIL stag_in_ready c=%0d: got %b expected %b", c, io.in_ready, rdy_in[c]); end
      tick();
    end
    drive(1'b0, 1'b0, '0, 9'h007, 9'h000);
    checks++; if (stall_count !== 16'd4) begin errors++; $display("FAIL stag_stall: got %0d expected 4", stall_count); end
    checks++; if (io.out_valid !== 9'h007 || io.out_data !== 17'h00042) begin errors++; $display("FAIL stag_second: got %h/%h expected 007/00042", io.out_valid, io.out_data); end
  endtask

  task automatic test_config_change();
    do_reset();
    drive(1'b0, 1'b1, 17'h0AAAA, 9'h003, 9'h000);
    tick();
    drive(1'b0, 1'b0, '0, 9'h100, 9'h000);
    checks++; if (io.out_valid !== 9'h003) begin errors++; $display("FAIL cfg_hold: got %h expected 003", io.out_valid); end
    tick();
    drive(1'b0, 1'b0, '0, 9'h100, 9'h1FF);
    checks++; if (io.out_valid !== 9'h003 || io.out_data !== 17'h0AAAA) begin errors++; $display("FAIL cfg_inflight: got %h/%h expected 003/0aaaa", io.out_valid, io.out_data); end
    tick();
    drive(1'b0, 1'b1, 17'h05555, 9'h100, 9'h000);
    checks++; if (io.out_valid !== 9'h000) begin errors++; $display("FAIL cfg_done: got %h expected 000", io.out_valid); end
    tick();
    drive(1'b0, 1'b0, '0, 9'h003, 9'h000);
    checks++; if (io.out_valid !== 9'h100 || io.out_data !== 17'h05555) begin errors++; $display("FAIL cfg_next: got %h/%h expected 100/05555", io.out_valid, io.out_data); end
  endtask

  task automatic test_empty_route();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, DW'(17'h00100 + k), 9'h000, 9'h000);
      checks++; if (io.in_ready !== 1'b1 || io.out_valid !== 9'h000) begin errors++; $display("FAIL empty k=%0d: got %b/%h expected 1/000", k, io.in_ready, io.out_valid); end
      tick();
    end
    drive(1'b0, 1'b0, '0, 9'h000, 9'h000);
    checks++; if (tok_count !== 16'd3 || busy !== 1'b0) begin errors++; $display("FAIL empty_count: got %0d/%b expected 3/0", tok_count, busy); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    drive(1'b0, 1'b1, 17'h01111, 9'h0F0, 9'h000);
    tick();
    // Flush while no destination is ready: in_ready low.
    drive(1'b1, 1'b1, 17'h02222, 9'h0F0, 9'h000);
    checks++; if (io.out_valid !== 9'h0F0 || io.in_ready !== 1'b0) begin errors++; $display("FAIL fl_pre: got %h/%b expected 0f0/0", io.out_valid, io.in_ready); end
    tick();
    drive(1'b0, 1'b0, '0, 9'h0F0, 9'h000);
    checks++; if (io.out_valid !== 9'h000 || tok_count !== 16'd1 || io.out_data !== 17'h01111) begin errors++; $display("FAIL fl_post: got %h/%0d/%h expected 000/1/01111", io.out_valid, tok_count, io.out_data); end
    tick();
    drive(1'b0, 1'b1, 17'h03333, 9'h0F0, 9'h000);
    tick();
    // Flush while last destinations are ready: in_ready high, accept discarded.
    drive(1'b1, 1'b1, 17'h04444, 9'h0F0, 9'h0F0);
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL fl_acc_ready: got %b expected 1", io.in_ready); end
    tick();
    drive(1'b0, 1'b0, '0, 9'h0F0, 9'h000);
    checks++; if (io.out_valid !== 9'h000 || tok_count !== 16'd2 || io.out_data !== 17'h03333) begin errors++; $display("FAIL fl_acc_post: got %h/%0d/%h expected 000/2/03333", io.out_valid, tok_count, io.out_data); end
    tick();
    drive(1'b0, 1'b1, 17'h05555, 9'h0F0, 9'h000);
    tick();
    drive(1'b0, 1'b0, '0, 9'h0F0, 9'h000);
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (io.out_valid !== 9'h000 || busy !== 1'b0 || io.in_ready !== 1'b1) begin errors++; $display("FAIL arst_out: got %h/%b/%b expected 000/0/1", io.out_valid, busy, io.in_ready); end
    checks++; if (tok_count !== 16'd0 || stall_count !== 16'd0 || io.out_data !== '0) begin errors++; $display("FAIL arst_cnt: got %0d/%0d/%h expected 0/0/0", tok_count, stall_count, io.out_data); end
    do_reset();
  endtask

  task automatic test_saturation();
    int exp_s;
    do_reset();
    @(negedge clk);
    cfg_route = 9'h1FF;
    io_s.in_valid = 1'b1;
    io_s.out_ready = 9'h1FF;
    for (int k = 0; k < 20; k++) begin
      io_s.in_data = DW'(k);
      @(negedge clk);
    end
    #1;
    exp_s = (20 > 15) ? 15 : 20;
    checks++; if (tok_count_s !== 4'(exp_s)) begin errors++; $display("FAIL sat_tok: got %0d expected %0d", tok_count_s, exp_s); end
    io_s.out_ready = 9'h000;
    repeat (21) @(negedge clk);
    #1;
    checks++; if (stall_count_s !== 4'd15 || tok_count_s !== 4'd15) begin errors++; $display("FAIL sat_stall: got %0d/%0d expected 15/15", stall_count_s, tok_count_s); end
    io_s.in_valid = 1'b0;
    io_s.out_ready = 9'h1FF;
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [NO-1:0] cfg, rdy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      cfg = ($urandom_range(0, 7) == 0) ? '0 : r[NO-1:0];
      r = $urandom;
      rdy = ($urandom_range(0, 3) == 0) ? 9'h1FF : r[NO-1:0];
      r = $urandom;
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, r[DW-1:0], cfg, rdy);
      checks++; if (io.in_ready !== exp_in_ready()) begin errors++; $display("FAIL rnd_in_ready c=%0d: got %b expected %b", c, io.in_ready, exp_in_ready()); end
      checks++; if (io.out_valid !== exp_out_valid()) begin errors++; $display("FAIL rnd_out_valid c=%0d: got %h expected %h", c, io.out_valid, exp_out_valid()); end
      checks++; if (io.out_data !== exp_out_data()) begin errors++; $display("FAIL rnd_out_data c=%0d: got %h expected %h", c, io.out_data, exp_out_data()); end
      checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, exp_busy()); end
      checks++; if (tok_count !== 16'(m_tok) || stall_count !== 16'(m_stall)) begin errors++; $display("FAIL rnd_counts c=%0d: got %0d/%0d expected %0d/%0d", c, tok_count, stall_count, m_tok, m_stall); end
      tick();
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    rst_n = 1'b1;
    flush = 1'b0;
    cfg_route = '0;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.out_ready = '0;
    io_s.in_valid = 1'b0;
    io_s.in_data = '0;
    io_s.out_ready = '0;
    model_reset();
    test_reset();
    test_broadcast();
    test_staggered();
    test_config_change();
    test_empty_route();
    test_flush_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
